// File: rtl/machine_line_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : machine_line_decoder_if
// Purpose  : Byte-stream inbound and decoded wiring outbound signals of the
//            machine line decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface machine_line_decoder_if #(
  parameter int MAX_WIRING_WIDTH = 16
);
  logic                        inbound_valid;
  logic [7:0]                  inbound_data;
  logic                        end_of_file;
  logic                        end_of_line;
  logic                        wiring_valid;
  logic [MAX_WIRING_WIDTH-1:0] wiring_data;
  logic                        parse_error;

  modport master (
    output inbound_valid,
    output inbound_data,
    input  end_of_file,
    input  end_of_line,
    input  wiring_valid,
    input  wiring_data,
    input  parse_error
  );

  modport slave (
    input  inbound_valid,
    input  inbound_data,
    output end_of_file,
    output end_of_line,
    output wiring_valid,
    output wiring_data,
    output parse_error
  );
endinterface
`default_nettype wire

// File: rtl/machine_line_decoder.sv
`default_nettype none
// ============================================================================
// Module   : machine_line_decoder
// Purpose  : Parses ASCII machine lines ([lights] (buttons) {joltage}) into
//            wiring bitmasks, one byte per cycle, with line/file framing.
// Revision : 1.0 - initial release
// ============================================================================
module machine_line_decoder #(
  parameter int MAX_WIRING_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  machine_line_decoder_if.slave   io_bus
);

  localparam int                          c_IDX_W   = $clog2(MAX_WIRING_WIDTH + 1);
  localparam int                          c_CALC_W  = c_IDX_W + 4;
  localparam logic [c_IDX_W-1:0]          c_IDX_MAX = '1;
  localparam logic [c_IDX_W-1:0]          c_WIDTH   = c_IDX_W'(MAX_WIRING_WIDTH);
  localparam logic [MAX_WIRING_WIDTH-1:0] c_ONE     = MAX_WIRING_WIDTH'(1);

  localparam logic [7:0] c_NUL    = 8'h00;
  localparam logic [7:0] c_LF     = 8'h0A;
  localparam logic [7:0] c_CR     = 8'h0D;
  localparam logic [7:0] c_SPACE  = 8'h20;
  localparam logic [7:0] c_HASH   = 8'h23;
  localparam logic [7:0] c_LPAREN = 8'h28;
  localparam logic [7:0] c_RPAREN = 8'h29;
  localparam logic [7:0] c_COMMA  = 8'h2C;
  localparam logic [7:0] c_DOT    = 8'h2E;
  localparam logic [7:0] c_LBRACK = 8'h5B;
  localparam logic [7:0] c_RBRACK = 8'h5D;
  localparam logic [7:0] c_LBRACE = 8'h7B;
  localparam logic [7:0] c_RBRACE = 8'h7D;

  typedef enum logic [2:0] {
    ST_GAP     = 3'd0,
    ST_LIGHTS  = 3'd1,
    ST_BUTTON  = 3'd2,
    ST_JOLTAGE = 3'd3,
    ST_SKIP    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                      r_state,  w_state_nxt;
  logic [MAX_WIRING_WIDTH-1:0] r_acc,    w_acc_nxt;
  logic [c_IDX_W-1:0]          r_idx,    w_idx_nxt;
  logic                        r_dig,    w_dig_nxt;
  logic                        r_any,    w_any_nxt;
  logic                        r_line,   w_line_nxt;
  logic                        r_wvalid, w_wvalid_nxt;
  logic [MAX_WIRING_WIDTH-1:0] r_wdata,  w_wdata_nxt;
  logic                        r_eol,    w_eol_nxt;
  logic                        r_eof,    w_eof_nxt;
  logic                        r_eof_pend, w_eof_pend_nxt;
  logic                        r_perr,   w_perr_nxt;

  logic [7:0]                  w_byte;
  logic                        w_is_digit;
  logic                        w_in_group;
  logic [c_CALC_W-1:0]         w_idx_calc;
  logic [c_IDX_W-1:0]          w_idx_sat;
  logic [MAX_WIRING_WIDTH-1:0] w_bit;
  logic [MAX_WIRING_WIDTH-1:0] w_emit_data;
  logic                        w_emit;
  logic                        w_err;
  logic                        w_nl;
  logic                        w_clr;

  assign w_byte     = io_bus.inbound_data;
  assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);
  assign w_in_group = (r_state == ST_LIGHTS) || (r_state == ST_BUTTON) ||
                      (r_state == ST_JOLTAGE);
  assign w_bit      = c_ONE << r_idx;

  // Index accumulates in a wider word and clamps so a long digit run never wraps
  assign w_idx_calc = ({4'b0000, r_idx} * c_CALC_W'(10)) + c_CALC_W'(w_byte[3:0]);
  assign w_idx_sat  = (w_idx_calc > c_CALC_W'(c_IDX_MAX)) ? c_IDX_MAX
                                                          : w_idx_calc[c_IDX_W-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_idx_nxt      = r_idx;
    w_dig_nxt      = r_dig;
    w_any_nxt      = r_any;
    w_line_nxt     = r_line;
    w_wvalid_nxt   = 1'b0;
    w_wdata_nxt    = r_wdata;
    w_eol_nxt      = 1'b0;
    w_eof_nxt      = r_eof | r_eof_pend;
    w_eof_pend_nxt = 1'b0;
    w_perr_nxt     = r_perr;
    w_emit_data    = r_acc;
    w_emit         = 1'b0;
    w_err          = 1'b0;
    w_nl           = 1'b0;
    w_clr          = 1'b0;

    if (io_bus.inbound_valid && (r_state != ST_DONE)) begin
      if (w_byte == c_NUL) begin
        // An errored line never closes with end_of_line, even at end of input
        if (r_line && (r_state != ST_SKIP)) begin
          w_eol_nxt      = 1'b1;
          w_eof_pend_nxt = 1'b1;
        end else begin
          w_eof_nxt = 1'b1;
        end
        if (w_in_group) begin
          w_perr_nxt = 1'b1;
        end
        w_state_nxt = ST_DONE;
        w_line_nxt  = 1'b0;
        w_clr       = 1'b1;
      end else begin
        case (r_state)
          ST_GAP: begin
            if (w_byte == c_LBRACK) begin
              w_state_nxt = ST_LIGHTS;
            end else if (w_byte == c_LPAREN) begin
              w_state_nxt = ST_BUTTON;
            end else if (w_byte == c_LBRACE) begin
              w_state_nxt = ST_JOLTAGE;
            end else if (w_byte == c_LF) begin
              w_nl = 1'b1;
            end else if ((w_byte != c_SPACE) && (w_byte != c_CR)) begin
              w_err = 1'b1;
            end
          end
          ST_LIGHTS: begin
            if ((w_byte == c_DOT) || (w_byte == c_HASH)) begin
              if (r_idx >= c_WIDTH) begin
                w_err = 1'b1;
              end else begin
                w_acc_nxt = (w_byte == c_HASH) ? (r_acc | w_bit) : (r_acc & ~w_bit);
                w_idx_nxt = r_idx + c_IDX_W'(1);
              end
            end else if (w_byte == c_RBRACK) begin
              w_emit = 1'b1;
            end else if (w_byte == c_LF) begin
              w_perr_nxt = 1'b1;
              w_nl       = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end
          ST_BUTTON: begin
            if (w_is_digit) begin
              if (w_idx_sat >= c_WIDTH) begin
                w_err = 1'b1;
              end else begin
                w_idx_nxt = w_idx_sat;
                w_dig_nxt = 1'b1;
              end
            end else if (w_byte == c_COMMA) begin
              if (!r_dig) begin
                w_err = 1'b1;
              end else begin
                w_acc_nxt = r_acc | w_bit;
                w_idx_nxt = '0;
                w_dig_nxt = 1'b0;
                w_any_nxt = 1'b1;
              end
            end else if (w_byte == c_RPAREN) begin
              // A trailing comma leaves no index to close; bare "()" is legal
              if (r_dig) begin
                w_emit_data = r_acc | w_bit;
                w_emit      = 1'b1;
              end else if (r_any) begin
                w_err = 1'b1;
              end else begin
                w_emit = 1'b1;
              end
            end else if (w_byte == c_LF) begin
              w_perr_nxt = 1'b1;
              w_nl       = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end
          ST_JOLTAGE: begin
            if (w_byte == c_RBRACE) begin
              w_state_nxt = ST_GAP;
            end else if (w_byte == c_LF) begin
              w_perr_nxt = 1'b1;
              w_nl       = 1'b1;
            end
          end
          ST_SKIP: begin
            if (w_byte == c_LF) begin
              w_state_nxt = ST_GAP;
              w_line_nxt  = 1'b0;
              w_clr       = 1'b1;
            end
          end
          default: begin
            w_state_nxt = r_state;
          end
        endcase
      end
    end

    if (w_emit) begin
      w_wvalid_nxt = 1'b1;
      w_wdata_nxt  = w_emit_data;
      w_line_nxt   = 1'b1;
      w_state_nxt  = ST_GAP;
      w_clr        = 1'b1;
    end
    if (w_err) begin
      w_perr_nxt  = 1'b1;
      w_state_nxt = ST_SKIP;
      w_clr       = 1'b1;
    end
    if (w_nl) begin
      w_eol_nxt   = r_line;
      w_line_nxt  = 1'b0;
      w_state_nxt = ST_GAP;
      w_clr       = 1'b1;
    end
    if (w_clr) begin
      w_acc_nxt = '0;
      w_idx_nxt = '0;
      w_dig_nxt = 1'b0;
      w_any_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_GAP;
      r_acc      <= '0;
      r_idx      <= '0;
      r_dig      <= 1'b0;
      r_any      <= 1'b0;
      r_line     <= 1'b0;
      r_wvalid   <= 1'b0;
      r_wdata    <= '0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_eof_pend <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_idx      <= w_idx_nxt;
      r_dig      <= w_dig_nxt;
      r_any      <= w_any_nxt;
      r_line     <= w_line_nxt;
      r_wvalid   <= w_wvalid_nxt;
      r_wdata    <= w_wdata_nxt;
      r_eol      <= w_eol_nxt;
      r_eof      <= w_eof_nxt;
      r_eof_pend <= w_eof_pend_nxt;
      r_perr     <= w_perr_nxt;
    end
  end

  assign io_bus.wiring_valid = r_wvalid;
  assign io_bus.wiring_data  = r_wdata;
  assign io_bus.end_of_line  = r_eol;
  assign io_bus.end_of_file  = r_eof;
  assign io_bus.parse_error  = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_machine_line_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_machine_line_decoder
// Purpose  : Scoreboard bench for machine_line_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_machine_line_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Event word: {end_of_line, wiring_valid, data}
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  logic [17:0] e_ev;
  logic [17:0] o_ev;

  machine_line_decoder_if #(.MAX_WIRING_WIDTH(16)) bus ();

  machine_line_decoder #(.MAX_WIRING_WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic cycle(input logic v, input logic [7:0] d);
    @(negedge clk);
    if (bus.wiring_valid || bus.end_of_line)
      obs_q.push_back({bus.end_of_line, bus.wiring_valid,
                       bus.wiring_valid ? bus.wiring_data : 16'h0000});
    bus.inbound_valid = v;
    bus.inbound_data  = d;
  endtask

  task automatic send_str(input string s, input bit gapped);
    for (int i = 0; i < s.len(); i++) begin
      cycle(1'b1, s[i]);
      if (gapped) cycle(1'b0, 8'h00);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.inbound_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic push_w(input logic [15:0] d);
    exp_q.push_back({2'b01, d});
  endtask

  task automatic push_eol();
    exp_q.push_back({2'b10, 16'h0000});
  endtask

  task automatic test_reset();
    bus.inbound_valid = 1'b0;
    bus.inbound_data  = 8'h00;
    #1;
    total++; if (bus.wiring_valid !== 1'b0) begin bad++; $display("FAIL reset_wvalid: got %b expected 0", bus.wiring_valid); end
    total++; if (bus.wiring_data !== 16'h0000) begin bad++; $display("FAIL reset_wdata: got %h expected 0000", bus.wiring_data); end
    total++; if (bus.end_of_line !== 1'b0) begin bad++; $display("FAIL reset_eol: got %b expected 0", bus.end_of_line); end
    total++; if (bus.end_of_file !== 1'b0) begin bad++; $display("FAIL reset_eof: got %b expected 0", bus.end_of_file); end
    total++; if (bus.parse_error !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b expected 0", bus.parse_error); end
    #3 rst_n = 1'b1;
    repeat (3) cycle(1'b0, 8'h00);
    total++; if (obs_q.size() != 0 || bus.end_of_file !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got %0d pulses eof=%b expected 0 pulses eof=0", obs_q.size(), bus.end_of_file);
    end
  endtask

  task automatic test_basic();
    do_reset();
    push_w(16'h0006); push_w(16'h0008); push_w(16'h000A); push_w(16'h0004);
    push_w(16'h000C); push_w(16'h0005); push_w(16'h0003); push_eol();
    send_str("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL basic_missing: got none expected %h", e_ev); end
      else begin o_ev = obs_q.pop_front(); if (o_ev !== e_ev) begin bad++; $display("FAIL basic_event: got %h expected %h", o_ev, e_ev); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL basic_extra: got %0d extra events expected 0", obs_q.size()); end
    total++; if (bus.parse_error !== 1'b0) begin bad++; $display("FAIL basic_perr: got %b expected 0", bus.parse_error); end
  endtask

  task automatic test_multidigit();
    do_reset();
    push_w(16'h0001); push_w(16'h1000); push_w(16'h0001); push_eol();
    send_str("[#] (12,12) (0)\n", 1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL multi_missing: got none expected %h", e_ev); end
      else begin o_ev = obs_q.pop_front(); if (o_ev !== e_ev) begin bad++; $display("FAIL multi_event: got %h expected %h", o_ev, e_ev); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL multi_extra: got %0d extra events expected 0", obs_q.size()); end
    total++; if (bus.parse_error !== 1'b0) begin bad++; $display("FAIL multi_perr: got %b expected 0", bus.parse_error); end
  endtask

  task automatic test_error_recovery();
    do_reset();
    push_w(16'h0001); push_w(16'h0002); push_w(16'h0001); push_eol();
    send_str("[#.] (1", 1'b0);
    cycle(1'b0, 8'h00);
    total++; if (bus.parse_error !== 1'b0) begin bad++; $display("FAIL err_early: got %b expected 0", bus.parse_error); end
    send_str("7", 1'b0);
    cycle(1'b0, 8'h00);
    total++; if (bus.parse_error !== 1'b1) begin bad++; $display("FAIL err_set: got %b expected 1", bus.parse_error); end
    send_str(") (1)\n[.#] (0)\n", 1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL err_missing: got none expected %h", e_ev); end
      else begin o_ev = obs_q.pop_front(); if (o_ev !== e_ev) begin bad++; $display("FAIL err_event: got %h expected %h", o_ev, e_ev); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL err_extra: got %0d extra events expected 0", obs_q.size()); end
    total++; if (bus.parse_error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b expected 1", bus.parse_error); end
  endtask

  task automatic test_eof();
    do_reset();
    send_str("\n", 1'b0);
    cycle(1'b1, 8'h00);
    cycle(1'b0, 8'h00);
    total++; if (bus.end_of_file !== 1'b1) begin bad++; $display("FAIL eof_empty: got %b expected 1", bus.end_of_file); end
    repeat (2) cycle(1'b0, 8'h00);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL eof_empty_pulse: got %0d events expected 0", obs_q.size()); end

    do_reset();
    push_w(16'h0001); push_w(16'h0001); push_eol();
    send_str("[#] (0)", 1'b0);
    cycle(1'b1, 8'h00);
    total++; if (bus.end_of_file !== 1'b0) begin bad++; $display("FAIL eof_t0: got %b expected 0", bus.end_of_file); end
    cycle(1'b0, 8'h00);
    total++; if (bus.end_of_line !== 1'b1 || bus.end_of_file !== 1'b0) begin
      bad++; $display("FAIL eof_t1: got eol=%b eof=%b expected eol=1 eof=0", bus.end_of_line, bus.end_of_file);
    end
    cycle(1'b0, 8'h00);
    total++; if (bus.end_of_file !== 1'b1 || bus.end_of_line !== 1'b0) begin
      bad++; $display("FAIL eof_t2: got eol=%b eof=%b expected eol=0 eof=1", bus.end_of_line, bus.end_of_file);
    end
    send_str("(1)\n", 1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL eof_missing: got none expected %h", e_ev); end
      else begin o_ev = obs_q.pop_front(); if (o_ev !== e_ev) begin bad++; $display("FAIL eof_event: got %h expected %h", o_ev, e_ev); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL eof_extra: got %0d extra events expected 0", obs_q.size()); end
    total++; if (bus.end_of_file !== 1'b1) begin bad++; $display("FAIL eof_sticky: got %b expected 1", bus.end_of_file); end
  endtask

  task automatic test_gapped();
    do_reset();
    send_str("\n\n", 1'b1);
    repeat (2) cycle(1'b0, 8'h00);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL gap_blank: got %0d events expected 0", obs_q.size()); end
    push_w(16'h0003); push_eol();
    send_str("[##]\n", 1'b1);
    repeat (3) cycle(1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL gap_missing: got none expected %h", e_ev); end
      else begin o_ev = obs_q.pop_front(); if (o_ev !== e_ev) begin bad++; $display("FAIL gap_event: got %h expected %h", o_ev, e_ev); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL gap_extra: got %0d extra events expected 0", obs_q.size()); end
  endtask

  task automatic test_reset_midline();
    do_reset();
    push_w(16'h0001);
    send_str("[#] [#. (", 1'b0);
    cycle(1'b0, 8'h00);
    total++; if (bus.parse_error !== 1'b1 || bus.wiring_data !== 16'h0001) begin
      bad++; $display("FAIL mid_pre: got perr=%b data=%h expected perr=1 data=0001", bus.parse_error, bus.wiring_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.parse_error !== 1'b0) begin bad++; $display("FAIL mid_async_perr: got %b expected 0", bus.parse_error); end
    total++; if (bus.wiring_data !== 16'h0000) begin bad++; $display("FAIL mid_async_wdata: got %h expected 0000", bus.wiring_data); end
    total++; if (bus.wiring_valid !== 1'b0 || bus.end_of_line !== 1'b0 || bus.end_of_file !== 1'b0) begin
      bad++; $display("FAIL mid_async_pulses: got wv=%b eol=%b eof=%b expected 0 0 0", bus.wiring_valid, bus.end_of_line, bus.end_of_file);
    end
    #1 rst_n = 1'b1;
    push_w(16'h0002); push_eol();
    send_str("[.#]\n", 1'b0);
    repeat (3) cycle(1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      e_ev = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL mid_missing: got none expected %h", e_ev); end
      else begin o_ev = obs_q.pop_front(); if (o_ev !== e_ev) begin bad++; $display("FAIL mid_event: got %h expected %h", o_ev, e_ev); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_extra: got %0d extra events expected 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multidigit();
    test_error_recovery();
    test_eof();
    test_gapped();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/machine_line_decoder.md
MACHINE_LINE_DECODER -- requirements
Module: machine_line_decoder

Interface
REQ-001 The block SHALL have parameter MAX_WIRING_WIDTH, default 16, giving the wiring bitmask width, i.e. the maximum light/button index + 1.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port inbound_valid, input, 1 bit: an ASCII byte is presented this cycle; no backpressure, one byte accepted per cycle.
REQ-005 The block SHALL have port inbound_data, input, 8 bits: ASCII puzzle byte.
REQ-006 The block SHALL have port end_of_file, output, 1 bit: sticky level, high once input is exhausted.
REQ-007 The block SHALL have port end_of_line, output, 1 bit: one-cycle pulse closing a machine line.
REQ-008 The block SHALL have port wiring_valid, output, 1 bit: one-cycle pulse qualifying wiring_data.
REQ-009 The block SHALL have port wiring_data, output, MAX_WIRING_WIDTH bits: decoded bitmask.
REQ-010 The block SHALL have port parse_error, output, 1 bit: sticky flag for malformed input.

Function
REQ-011 The parser FSM SHALL have states GAP (between groups), LIGHTS (inside []), BUTTON (inside ()), JOLTAGE (inside {}), SKIP (discard to newline) and DONE.
REQ-012 In GAP, '[' SHALL go to LIGHTS, '(' to BUTTON and '{' to JOLTAGE; space and '\r' SHALL be ignored; '\n' SHALL close the line; any other byte SHALL set parse_error and go to SKIP.
REQ-013 In LIGHTS, the k-th '.'/'#' (k from 0) SHALL clear/set bit k of the accumulator, and ']' SHALL emit the accumulator and return to GAP.
REQ-014 In BUTTON, decimal digits SHALL accumulate index = index*10 + digit; ',' or ')' SHALL OR bit[index] into the accumulator; ')' SHALL then emit it and return to GAP.
REQ-015 Duplicate indices SHALL OR without error; "()" SHALL emit 0.
REQ-016 JOLTAGE SHALL discard all bytes until '}', then return to GAP; no output.
REQ-017 An emission SHALL drive wiring_valid=1 and wiring_data=accumulator in the cycle after the closing byte is accepted; the accumulator and index SHALL then clear.
REQ-018 Emission order SHALL follow the input: the light pattern first, then buttons left to right.
REQ-019 '\n' in GAP SHALL pulse end_of_line the next cycle only if at least one wiring was emitted on that line; empty lines SHALL produce nothing.
REQ-020 A light position >= MAX_WIRING_WIDTH, a button index >= MAX_WIRING_WIDTH, any unexpected byte inside LIGHTS/BUTTON, or '\n' inside an open group SHALL set parse_error and go to SKIP (or behave as REQ-019 if the byte was '\n' and nothing partial is emitted).
REQ-021 SKIP SHALL discard bytes until '\n', then go to GAP without an end_of_line pulse; all wirings already emitted on that line stay emitted.
REQ-022 Byte 0x00 SHALL mark end of input. If the current line has emitted wirings, end_of_line SHALL pulse the next cycle and end_of_file rise the cycle after; otherwise end_of_file SHALL rise the next cycle. The FSM SHALL then enter DONE.
REQ-023 In DONE, all inbound bytes SHALL be ignored and end_of_file SHALL stay high until reset.
REQ-024 wiring_valid and end_of_line SHALL never be high in the same cycle and SHALL be low whenever inbound_valid was low the previous cycle, except for the REQ-022 sequence.
REQ-025 Throughput SHALL be one byte per cycle with no stalls; the index accumulator SHALL saturate rather than wrap; overflow is covered by REQ-020.

Reset
REQ-026 On rst_n low, immediately and regardless of clk: FSM = GAP; accumulator, index and line-has-content flag cleared; end_of_file, end_of_line, wiring_valid and parse_error = 0; wiring_data = 0.
REQ-027 Reset asserted mid-line SHALL discard the partial line with no pulses; the first byte after deassertion SHALL be parsed as the start of a new line.

Verification
REQ-028 Basic line: "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n" SHALL yield wirings 0x0006, 0x0008, 0x000A, 0x0004, 0x000C, 0x0005, 0x0003, then one end_of_line pulse.
REQ-029 Multi-digit and duplicate: "[#] (12,12) (0)\n" SHALL yield 0x0001, 0x1000, 0x0001, then end_of_line; parse_error stays 0.
REQ-030 Error and recovery: "[#.] (17) (1)\n[.#] (0)\n" SHALL emit 0x0001, set parse_error on '7' of "17", emit nothing more on line 1 with no end_of_line, then emit 0x0002 and 0x0001 and end_of_line for line 2.
REQ-031 EOF without newline: "[#] (0)" then 0x00 SHALL give end_of_line at T+1 and end_of_file at T+2; subsequent "(1)" bytes SHALL produce no output.
REQ-032 Gapped input and blank lines: "\n\n" with idle cycles between bytes SHALL produce no pulses; "[##]\n" sent with inbound_valid low on alternate cycles SHALL emit 0x0003 then end_of_line.
REQ-033 Reset: rst_n pulsed low after "[#. (" SHALL clear all outputs asynchronously; then "[.#]\n" SHALL emit 0x0002 and end_of_line.
